sdrc_bist_gen: RTL

//  Synthesisable traffic generator/checker on the sdrc_core application port (app_req/app_wr_data/app_rd_data).

---
 rtl/sdrc_bist_gen.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sdrc_bist_gen.sv
// ---------------------------------------------------------------------------
// sdrc_bist_gen -- traffic generator / checker for the sdrc_core app port.
//
// Runs cfg_num_bursts write-then-read burst pairs. Burst b, word k carries
// D(b,k) = cfg_seed + {b,8'h00} + k. Read-back data is compared against the
// same pattern. Mismatches go to a saturating error counter. A read that
// stalls for 2**TMO_W-1 cycles counts its missing words as errors and marks
// the run failed.
//
// Build option:
//   SDRC_BIST_LFSR_ADDR_EN  - burst addresses after the first come from a
//                             32-bit Galois LFSR (taps 0x80200003) instead
//                             of the linear stride.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   bist_start / bist_abort      run control (pulse / level)
//   cfg_*                        run configuration, latched on start
//   app_req*, app_wr_*, app_rd_* sdrc_core application port
//   bist_busy/done/pass, err_cnt run status
// ---------------------------------------------------------------------------
module sdrc_bist_gen #(
  parameter int APP_AW = 30,
  parameter int DW     = 32,
  parameter int LEN_W  = 9,
  parameter int CNT_W  = 16,
  parameter int TMO_W  = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bist_start,
  input  logic              bist_abort,
  input  logic [APP_AW-1:0] cfg_start_addr,
  input  logic [APP_AW-1:0] cfg_addr_stride,
  input  logic [APP_AW-1:0] cfg_addr_mask,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  cfg_num_bursts,
  input  logic [7:0]        cfg_gap,
  input  logic [DW-1:0]     cfg_seed,
  output logic              app_req,
  output logic [APP_AW-1:0] app_req_addr,
  output logic [LEN_W-1:0]  app_req_len,
  output logic              app_req_wr_n,
  input  logic              app_req_ack,
  output logic [DW-1:0]     app_wr_data,
  output logic [DW/8-1:0]   app_wr_en_n,
  input  logic              app_wr_next_req,
  input  logic              app_rd_valid,
  input  logic [DW-1:0]     app_rd_data,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_DATA, S_GAP, S_RD_REQ, S_RD_DATA, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nxt;

  // latched run configuration
  logic [APP_AW-1:0] stride_q, mask_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  num_q;
  logic [7:0]        gap_q;
  logic [DW-1:0]     seed_q;

  // run progress
  logic [APP_AW-1:0] addr_q, addr_step;
  logic [CNT_W-1:0]  b_q;
  logic [LEN_W-1:0]  k_q;
  logic [7:0]        gap_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [CNT_W-1:0]  err_q;
  logic              tmo_flag;
  logic              busy_q, done_q, pass_q;

  logic [CNT_W:0]    b_nxt;
  logic [DW-1:0]     data_pat;
  logic              wr_take, wr_last, rd_take, rd_last, tmo_hit, mismatch;
  logic              cfg_empty;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign data_pat = seed_q + DW'({b_q, 8'h00}) + DW'(k_q);
  assign b_nxt    = {1'b0, b_q} + 1'b1;

  // A write word is consumed on any next_req cycle once the request has been
  // accepted, including the acknowledge cycle itself.
  assign wr_take  = app_wr_next_req &&
                    (state == S_WR_DATA || (state == S_WR_REQ && app_req_ack));
  assign wr_last  = wr_take && (k_q == len_q - 1'b1);
  assign rd_take  = (state == S_RD_DATA) && app_rd_valid;
  assign rd_last  = rd_take && (k_q == len_q - 1'b1);
  assign mismatch = app_rd_data != data_pat;
  assign tmo_hit  = (state == S_RD_DATA) && !app_rd_valid && (tmo_cnt == '1);
  assign cfg_empty = (cfg_len == '0) || (cfg_num_bursts == '0);

`ifdef SDRC_BIST_LFSR_ADDR_EN
  logic [31:0] lfsr_q, lfsr_nxt;

  // right-shifting Galois form; bit 0 feeds back through the tap mask
  assign lfsr_nxt  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
  assign addr_step = APP_AW'(lfsr_nxt) & mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      lfsr_q <= '0;
    else if (state == S_IDLE && bist_start)
      lfsr_q <= 32'(cfg_start_addr) | 32'd1;
    else if (state == S_NEXT)
      lfsr_q <= lfsr_nxt;
  end
`else
  assign addr_step = (addr_q + stride_q) & mask_q;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bist_start) state_nxt = cfg_empty ? S_DONE : S_WR_REQ;
      S_WR_REQ:  if (app_req_ack) begin
                   if (wr_last) state_nxt = (gap_q == '0) ? S_RD_REQ : S_GAP;
                   else         state_nxt = S_WR_DATA;
                 end
      S_WR_DATA: if (wr_last) state_nxt = (gap_q == '0) ? S_RD_REQ : S_GAP;
      S_GAP:     if (gap_cnt == 8'd1) state_nxt = S_RD_REQ;
      S_RD_REQ:  if (app_req_ack) state_nxt = S_RD_DATA;
      S_RD_DATA: if (rd_last || tmo_hit) state_nxt = S_NEXT;
      // abort is only looked at here, so a pair is never cut in half
      S_NEXT:    state_nxt = (b_nxt == {1'b0, num_q} || bist_abort) ? S_DONE
                                                                     : S_WR_REQ;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stride_q <= '0;
      mask_q   <= '0;
      len_q    <= '0;
      num_q    <= '0;
      gap_q    <= '0;
      seed_q   <= '0;
      addr_q   <= '0;
      b_q      <= '0;
      k_q      <= '0;
      gap_cnt  <= '0;
      tmo_cnt  <= '0;
      err_q    <= '0;
      tmo_flag <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bist_start) begin
          stride_q <= cfg_addr_stride;
          mask_q   <= cfg_addr_mask;
          len_q    <= cfg_len;
          num_q    <= cfg_num_bursts;
          gap_q    <= cfg_gap;
          seed_q   <= cfg_seed;
          addr_q   <= cfg_start_addr & cfg_addr_mask;
          b_q      <= '0;
          k_q      <= '0;
          err_q    <= '0;
          tmo_flag <= 1'b0;
          busy_q   <= 1'b1;
          done_q   <= 1'b0;
          pass_q   <= 1'b0;
        end
        S_WR_REQ, S_WR_DATA: if (wr_take) begin
          if (wr_last) begin
            k_q     <= '0;
            gap_cnt <= gap_q;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_GAP: gap_cnt <= gap_cnt - 1'b1;
        S_RD_REQ: if (app_req_ack) begin
          k_q     <= '0;
          tmo_cnt <= '0;
        end
        S_RD_DATA: begin
          if (app_rd_valid) begin
            tmo_cnt <= '0;
            k_q     <= rd_last ? '0 : k_q + 1'b1;
            if (mismatch) err_q <= sat_add(err_q, CNT_W'(1));
          end else if (tmo_hit) begin
            // words never delivered are charged as errors
            err_q    <= sat_add(err_q, CNT_W'(len_q - k_q));
            tmo_flag <= 1'b1;
            k_q      <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          b_q    <= b_nxt[CNT_W-1:0];
          addr_q <= addr_step;
        end
        S_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          pass_q <= (err_q == '0) && !tmo_flag;
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------- outputs
  assign app_req      = (state == S_WR_REQ) || (state == S_RD_REQ);
  assign app_req_wr_n = (state != S_WR_REQ);
  assign app_req_addr = addr_q;
  assign app_req_len  = len_q;
  assign app_wr_data  = data_pat;
  assign app_wr_en_n  = (state == S_WR_DATA || (state == S_WR_REQ && app_req_ack))
                        ? '0 : '1;
  assign bist_busy    = busy_q;
  assign bist_done    = done_q;
  assign bist_pass    = pass_q;
  assign err_cnt      = err_q;

endmodule
